// File: rtl/stim_pkg.sv
// ============================================================================
// Module : stim_pkg
// Purpose: Shared definitions for the filter stimulus generator: mode
//          encodings, controller state enum and LFSR constants/helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stim_pkg;

   // Stimulus mode encodings
   localparam logic [2:0] MODE_ZERO     = 3'd0;
   localparam logic [2:0] MODE_IMPULSE  = 3'd1;
   localparam logic [2:0] MODE_PIMPULSE = 3'd2;
   localparam logic [2:0] MODE_STEP     = 3'd3;
   localparam logic [2:0] MODE_SQUARE   = 3'd4;
   localparam logic [2:0] MODE_PN       = 3'd5;
   localparam logic [2:0] MODE_RAMP     = 3'd6;
   localparam logic [2:0] MODE_RSVD     = 3'd7;

   // Run controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // PN generator: x^15 + x^14 + 1, Fibonacci form
   localparam int              LFSR_W     = 15;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
   localparam int              LFSR_TAP_A = 14;   // x^15 term (MSB)
   localparam int              LFSR_TAP_B = 13;   // x^14 term

   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return s[LFSR_TAP_A] ^ s[LFSR_TAP_B];
   endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_pn.sv
// ============================================================================
// Module : lfsr_pn
// Purpose: 15-bit Fibonacci LFSR (x^15 + x^14 + 1) for PN stimulus.
// Ports  : sys_clk  - clock, rising edge
//          reset    - asynchronous active-low reset (to seed)
//          load     - reload the seed (has priority over step)
//          step     - advance one position
//          bit_out  - current LSB of the register
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_pn
   import stim_pkg::*;
(
   input  logic sys_clk,
   input  logic reset,
   input  logic load,
   input  logic step,
   output logic bit_out
);

   logic [LFSR_W-1:0] r_lfsr;

   // Shift towards the MSB; new feedback bit enters at bit 0, which is
   // the bit presented to the sample mux.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_lfsr <= LFSR_SEED;
      end else if (load) begin
         r_lfsr <= LFSR_SEED;
      end else if (step) begin
         r_lfsr <= {r_lfsr[LFSR_W-2:0], lfsr_fb(r_lfsr)};
      end
   end

   assign bit_out = r_lfsr[0];

endmodule

`default_nettype wire

// File: rtl/filter_stim_gen.sv
// ============================================================================
// Module : filter_stim_gen
// Purpose: On-chip stimulus source for the filter chain. Emits LEN samples
//          of the selected waveform (zero, impulse, periodic impulse, step,
//          square, PN, ramp) on successive sam_clk_en strobes.
// Ports  : sys_clk     - clock, rising edge
//          reset       - asynchronous active-low reset
//          sam_clk_en  - one-cycle sample strobe
//          start       - begin a run (accepted only in IDLE)
//          abort       - terminate the current run (no done)
//          mode[2:0]   - waveform select, latched on accepted start
//          x_out       - signed stimulus sample (registered)
//          x_valid     - one-cycle flag after each sample update
//          busy        - run in progress
//          done        - one-cycle pulse after a normally completed run
//          sample_idx  - index of the last emitted sample
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module filter_stim_gen
   import stim_pkg::*;
#(
   parameter int WIDTH  = 18,
   parameter int AMP    = 2**(WIDTH-1)-1,
   parameter int LEN    = 256,
   parameter int PERIOD = 64
) (
   input  logic                     sys_clk,
   input  logic                     reset,
   input  logic                     sam_clk_en,
   input  logic                     start,
   input  logic                     abort,
   input  logic [2:0]               mode,
   output logic signed [WIDTH-1:0]  x_out,
   output logic                     x_valid,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(LEN)-1:0]   sample_idx
);

   localparam int IDXW = $clog2(LEN);
   localparam int PHW  = $clog2(PERIOD);

   localparam logic [IDXW-1:0]         c_idx_last = IDXW'(LEN - 1);
   localparam logic [PHW-1:0]          c_ph_last  = PHW'(PERIOD - 1);
   localparam logic [PHW-1:0]          c_ph_half  = PHW'(PERIOD / 2);
   localparam logic signed [WIDTH-1:0] c_pos      = WIDTH'(AMP);
   localparam logic signed [WIDTH-1:0] c_neg      = -c_pos;

   state_t                   r_state;
   logic [2:0]               r_mode;
   logic [IDXW-1:0]          r_idx;
   logic [PHW-1:0]           r_phase;
   logic signed [WIDTH-1:0]  r_x;
   logic                     r_valid;
   logic                     r_done;
   logic [IDXW-1:0]          r_sidx;

   logic                     w_accept;
   logic                     w_emit;
   logic                     w_pn_bit;
   logic signed [WIDTH-1:0]  w_ramp;
   logic signed [WIDTH-1:0]  w_sample;

   assign w_accept = (r_state == ST_IDLE) && start;
   // Abort has priority over a coincident strobe, so such a strobe emits nothing.
   assign w_emit   = (r_state == ST_RUN) && sam_clk_en && !abort;

   lfsr_pn u_lfsr (
      .sys_clk (sys_clk),
      .reset   (reset),
      .load    (w_accept),
      .step    (w_emit),
      .bit_out (w_pn_bit)
   );

   // Index treated as a signed IDXW value, then sign-extended or truncated
   // to WIDTH so the ramp wraps in two's complement.
   assign w_ramp = WIDTH'($signed(r_idx));

   always_comb begin
      w_sample = '0;
      case (r_mode)
         MODE_ZERO:     w_sample = '0;
         MODE_IMPULSE:  w_sample = (r_idx == '0)      ? c_pos : '0;
         MODE_PIMPULSE: w_sample = (r_phase == '0)    ? c_pos : '0;
         MODE_STEP:     w_sample = c_pos;
         MODE_SQUARE:   w_sample = (r_phase < c_ph_half) ? c_pos : c_neg;
         MODE_PN:       w_sample = w_pn_bit ? c_pos : c_neg;
         MODE_RAMP:     w_sample = w_ramp;
         default:       w_sample = '0;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_ZERO;
         r_idx   <= '0;
         r_phase <= '0;
         r_x     <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_sidx  <= '0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_x <= '0;
               if (start) begin
                  r_state <= ST_RUN;
                  r_mode  <= mode;
                  r_idx   <= '0;
                  r_phase <= '0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_x     <= '0;
               end else if (sam_clk_en) begin
                  r_x     <= w_sample;
                  r_valid <= 1'b1;
                  r_sidx  <= r_idx;
                  r_idx   <= r_idx + IDXW'(1);
                  r_phase <= (r_phase == c_ph_last) ? '0 : r_phase + PHW'(1);
                  if (r_idx == c_idx_last) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_x     <= '0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_x     <= '0;
            end
         endcase
      end
   end

   assign x_out      = r_x;
   assign x_valid    = r_valid;
   assign busy       = (r_state == ST_RUN);
   assign done       = r_done;
   assign sample_idx = r_sidx;

endmodule

`default_nettype wire

// File: tb/tb_filter_stim_gen.sv
// ============================================================================
// Module : tb_filter_stim_gen
// Purpose: Directed self-checking bench for filter_stim_gen. One instance
//          with LEN=8/PERIOD=4, one with LEN=20 for the PN sequence.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_filter_stim_gen;

   localparam logic [17:0] C_POS = 18'd131071;
   localparam logic [17:0] C_NEG = 18'h20001;   // -131071 in 18 bits

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        sam_clk_en;
   logic        start;
   logic        start_pn;
   logic        abort;
   logic [2:0]  mode;

   logic [17:0] x_out;
   logic        x_valid, busy, done;
   logic [2:0]  sample_idx;

   logic [17:0] pn_x_out;
   logic        pn_x_valid, pn_busy, pn_done;
   logic [4:0]  pn_sample_idx;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   filter_stim_gen #(.WIDTH(18), .LEN(8), .PERIOD(4)) dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .sam_clk_en (sam_clk_en),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .x_out      (x_out),
      .x_valid    (x_valid),
      .busy       (busy),
      .done       (done),
      .sample_idx (sample_idx)
   );

   filter_stim_gen #(.WIDTH(18), .LEN(20), .PERIOD(64)) dut_pn (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .sam_clk_en (sam_clk_en),
      .start      (start_pn),
      .abort      (abort),
      .mode       (mode),
      .x_out      (pn_x_out),
      .x_valid    (pn_x_valid),
      .busy       (pn_busy),
      .done       (pn_done),
      .sample_idx (pn_sample_idx)
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic strobe();
      sam_clk_en = 1'b1;
      tick();
      sam_clk_en = 1'b0;
   endtask

   task automatic do_start(input logic [2:0] m);
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; sam_clk_en = 1'b0; start = 1'b0; start_pn = 1'b0;
      abort = 1'b0; mode = 3'd0;
      tick(); tick();
      checks++; if (x_out !== 18'd0) begin errors++; $display("FAIL rst_x got %0d want 0", x_out); end
      checks++; if ({x_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {x_valid, busy, done}); end
      checks++; if (sample_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got %0d want 0", sample_idx); end
      checks++; if ({pn_x_out, pn_x_valid, pn_busy, pn_done} !== 21'd0) begin errors++; $display("FAIL rst_pn got %h want 0", {pn_x_out, pn_x_valid, pn_busy, pn_done}); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_impulse();
      logic [17:0] exp;
      do_start(3'd1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL imp_busy got %b want 1", busy); end
      for (int i = 0; i < 8; i++) begin
         repeat (3) begin
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL imp_early_done[%0d] got %b want 0", i, done); end
         end
         strobe();
         exp = (i == 0) ? C_POS : 18'd0;
         checks++; if (x_out !== exp) begin errors++; $display("FAIL imp_x[%0d] got %0d want %0d", i, $signed(x_out), $signed(exp)); end
         checks++; if (x_valid !== 1'b1) begin errors++; $display("FAIL imp_valid[%0d] got %b want 1", i, x_valid); end
         checks++; if (sample_idx !== 3'(i)) begin errors++; $display("FAIL imp_idx[%0d] got %0d want %0d", i, sample_idx, i); end
      end
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL imp_end got busy,done=%b want 00", {busy, done}); end
      tick();
      checks++; if ({done, x_valid, busy} !== 3'b100) begin errors++; $display("FAIL imp_done got done,valid,busy=%b want 100", {done, x_valid, busy}); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL imp_done_width got %b want 0", done); end
   endtask

   task automatic test_square();
      logic [17:0] exp;
      do_start(3'd4);
      sam_clk_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp = ((i % 4) < 2) ? C_POS : C_NEG;
         checks++; if (x_out !== exp) begin errors++; $display("FAIL sq_x[%0d] got %0d want %0d", i, $signed(x_out), $signed(exp)); end
         checks++; if (sample_idx !== 3'(i)) begin errors++; $display("FAIL sq_idx[%0d] got %0d want %0d", i, sample_idx, i); end
         checks++; if (x_valid !== 1'b1) begin errors++; $display("FAIL sq_valid[%0d] got %b want 1", i, x_valid); end
      end
      sam_clk_en = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sq_busy got %b want 0", busy); end
      tick();
      checks++; if ({done, x_out} !== {1'b1, 18'd0}) begin errors++; $display("FAIL sq_done got done=%b x=%0d want 1,0", done, $signed(x_out)); end
      tick();
   endtask

   task automatic test_pn();
      logic [19:0] pn_ref;
      logic [17:0] exp;
      pn_ref = 20'h0C001;   // lfsr[0] for samples 0..19 from seed 1
      mode = 3'd5;
      for (int r = 0; r < 2; r++) begin
         start_pn = 1'b1;
         tick();
         start_pn = 1'b0;
         for (int k = 0; k < 20; k++) begin
            strobe();
            exp = pn_ref[k] ? C_POS : C_NEG;
            checks++; if (pn_x_out !== exp) begin errors++; $display("FAIL pn_x[run%0d,%0d] got %0d want %0d", r, k, $signed(pn_x_out), $signed(exp)); end
         end
         checks++; if (pn_busy !== 1'b0) begin errors++; $display("FAIL pn_busy[run%0d] got %b want 0", r, pn_busy); end
         tick();
         checks++; if (pn_done !== 1'b1) begin errors++; $display("FAIL pn_done[run%0d] got %b want 1", r, pn_done); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      mode  = 3'd3;
      start = 1'b1;
      tick();
      repeat (8) strobe();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end got busy=%b want 0", busy); end
      tick();
      checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done got done,busy=%b want 10", {done, busy}); end
      tick();
      checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL b2b_restart got done,busy=%b want 01", {done, busy}); end
      start = 1'b0;
      strobe();
      checks++; if ({sample_idx, x_out} !== {3'd0, C_POS}) begin errors++; $display("FAIL b2b_first got idx=%0d x=%0d want 0,131071", sample_idx, $signed(x_out)); end
      abort = 1'b1; tick(); abort = 1'b0;
   endtask

   task automatic test_ignore();
      logic [17:0] exp;
      do_start(3'd2);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            start = 1'b1;
            mode  = 3'd3;
         end
         strobe();
         start = 1'b0;
         exp = ((i % 4) == 0) ? C_POS : 18'd0;
         checks++; if (x_out !== exp) begin errors++; $display("FAIL ign_x[%0d] got %0d want %0d", i, $signed(x_out), $signed(exp)); end
         checks++; if (sample_idx !== 3'(i)) begin errors++; $display("FAIL ign_idx[%0d] got %0d want %0d", i, sample_idx, i); end
      end
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", done); end
      tick();
   endtask

   task automatic test_final_abort();
      do_start(3'd3);
      repeat (7) strobe();
      checks++; if ({busy, x_out} !== {1'b1, C_POS}) begin errors++; $display("FAIL fab_pre got busy=%b x=%0d want 1,131071", busy, $signed(x_out)); end
      abort = 1'b1;
      strobe();
      abort = 1'b0;
      checks++; if ({busy, x_valid, x_out} !== 20'd0) begin errors++; $display("FAIL fab_stop got busy=%b valid=%b x=%0d want 0,0,0", busy, x_valid, $signed(x_out)); end
      repeat (3) begin
         tick();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL fab_done got %b want 0", done); end
      end
   endtask

   task automatic test_abort();
      do_start(3'd3);
      for (int i = 0; i < 3; i++) begin
         strobe();
         checks++; if (x_out !== C_POS) begin errors++; $display("FAIL ab_x[%0d] got %0d want 131071", i, $signed(x_out)); end
      end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if ({busy, x_valid, x_out} !== 20'd0) begin errors++; $display("FAIL ab_stop got busy=%b valid=%b x=%0d want 0,0,0", busy, x_valid, $signed(x_out)); end
      repeat (3) begin
         tick();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_done got %b want 0", done); end
      end
      do_start(3'd3);
      strobe();
      checks++; if ({sample_idx, x_out} !== {3'd0, C_POS}) begin errors++; $display("FAIL ab_restart got idx=%0d x=%0d want 0,131071", sample_idx, $signed(x_out)); end
      abort = 1'b1; tick(); abort = 1'b0;
   endtask

   task automatic test_async_reset();
      do_start(3'd6);
      for (int i = 0; i < 3; i++) begin
         strobe();
         checks++; if (x_out !== 18'(i)) begin errors++; $display("FAIL ramp_x[%0d] got %0d want %0d", i, $signed(x_out), i); end
      end
      #2 reset = 1'b0;
      #1;
      checks++; if ({x_out, x_valid, busy, done, sample_idx} !== 24'd0) begin errors++; $display("FAIL arst got x=%0d valid=%b busy=%b done=%b idx=%0d want all 0", $signed(x_out), x_valid, busy, done, sample_idx); end
      #3 reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         strobe();
         checks++; if ({x_valid, busy} !== 2'b00) begin errors++; $display("FAIL arst_idle[%0d] got valid,busy=%b want 00", i, {x_valid, busy}); end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_square();
      test_pn();
      test_back_to_back();
      test_ignore();
      test_final_abort();
      test_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
